// File: rtl/mod_exp_64.sv
// Left-to-right square-and-multiply computing base^exp mod modulus. The modular
// multiplier is an interleaved shift-add that consumes one operand bit per cycle.
module mod_exp_64 (
  input  logic        clk,
  input  logic        rst,
  input  logic        start_i,
  input  logic [63:0] base_i,
  input  logic [63:0] exp_i,
  input  logic [63:0] mod_i,
  output logic [63:0] key_o,
  output logic        done_o,
  output logic        busy_o
);

  typedef enum logic [2:0] {StIdle, StReduce, StSqr, StMul, StDone} state_e;

  state_e      r_state, w_state_next;
  logic        r_start;
  logic [63:0] r_base, r_exp, r_mod;
  logic [63:0] r_acc, r_r, r_bred, r_key;
  logic [5:0]  r_cnt, r_idx;

  logic        w_accept, w_small, w_last;
  logic [63:0] w_a, w_b, w_t, w_u;
  logic [64:0] w_dbl, w_sum;

  // Operands are captured on the start edge; the FSM reacts one cycle later.
  assign w_accept = start_i && !r_start && (r_state == StIdle || r_state == StDone);
  assign w_small  = (r_mod[63:1] == 63'd0);
  assign w_last   = (r_cnt == 6'd0);

  // One step of acc = (2*acc + b[j]*a) mod m; both partial results stay below m.
  always_comb begin
    w_a = 64'd1;
    w_b = r_base;
    case (r_state)
      StSqr: begin
        w_a = r_r;
        w_b = r_r;
      end
      StMul: begin
        w_a = r_bred;
        w_b = r_r;
      end
      default: ;
    endcase
    w_dbl = {r_acc, 1'b0};
    w_t   = (w_dbl >= {1'b0, r_mod}) ? (w_dbl[63:0] - r_mod) : w_dbl[63:0];
    w_sum = {1'b0, w_t} + (w_b[r_cnt] ? {1'b0, w_a} : 65'd0);
    w_u   = (w_sum >= {1'b0, r_mod}) ? (w_sum[63:0] - r_mod) : w_sum[63:0];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= StIdle;
    else      r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      StIdle, StDone: begin
        if (r_start) w_state_next = w_small ? StDone : StReduce;
      end
      StReduce: begin
        if (w_last) w_state_next = StSqr;
      end
      StSqr: begin
        if (w_last) begin
          if (r_exp[r_idx])        w_state_next = StMul;
          else if (r_idx == 6'd0)  w_state_next = StDone;
          else                     w_state_next = StSqr;
        end
      end
      StMul: begin
        if (w_last) w_state_next = (r_idx == 6'd0) ? StDone : StSqr;
      end
      default: w_state_next = StIdle;
    endcase
  end

  always_comb begin
    busy_o = (r_state == StReduce) || (r_state == StSqr) || (r_state == StMul);
    done_o = (r_state == StDone);
    key_o  = r_key;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_start <= 1'b0;
      r_base  <= 64'd0;
      r_exp   <= 64'd0;
      r_mod   <= 64'd0;
      r_acc   <= 64'd0;
      r_r     <= 64'd0;
      r_bred  <= 64'd0;
      r_key   <= 64'd0;
      r_cnt   <= 6'd0;
      r_idx   <= 6'd0;
    end else begin
      r_start <= w_accept;
      if (w_accept) begin
        r_base <= base_i;
        r_exp  <= exp_i;
        r_mod  <= mod_i;
      end
      case (r_state)
        StIdle, StDone: begin
          if (r_start) begin
            r_acc <= 64'd0;
            r_cnt <= 6'd63;
            r_idx <= 6'd63;
            r_r   <= 64'd1;
            if (w_small) r_key <= 64'd0;
          end
        end
        StReduce, StSqr, StMul: begin
          // r_cnt wraps from 0 back to 63, ready for the next multiply.
          r_cnt <= r_cnt - 6'd1;
          r_acc <= w_last ? 64'd0 : w_u;
          if (w_last) begin
            if (r_state == StReduce) r_bred <= w_u;
            else                     r_r    <= w_u;
            if (w_state_next == StDone) r_key <= w_u;
            if (r_state != StReduce && w_state_next == StSqr) r_idx <= r_idx - 6'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mod_exp_64.sv
// Directed-vector bench for mod_exp_64: result, latency, busy span, and handshake corners.
module tb_mod_exp_64;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start_i = 1'b0;
  logic [63:0] base_i = 64'd0, exp_i = 64'd0, mod_i = 64'd0;
  logic [63:0] key_o;
  logic        done_o, busy_o;

  int n_checks = 0;
  int n_fail   = 0;

  mod_exp_64 dut (
    .clk    (clk),
    .rst    (rst),
    .start_i(start_i),
    .base_i (base_i),
    .exp_i  (exp_i),
    .mod_i  (mod_i),
    .key_o  (key_o),
    .done_o (done_o),
    .busy_o (busy_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       nm;
    logic [63:0] b;
    logic [63:0] e;
    logic [63:0] m;
    logic [63:0] key;
    int          lat;
  } vec_t;

  vec_t vecs[10];

  localparam logic [63:0] MBig = 64'hFFFF_FFFF_FFFF_FFC5;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%h), expected %0d (0x%h)", nm, act, act, req, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a start for one edge (edge N), then scramble operands to prove capture.
  task automatic do_start(input logic [63:0] b, input logic [63:0] e, input logic [63:0] m);
    base_i  = b;
    exp_i   = e;
    mod_i   = m;
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    base_i  = {$urandom, $urandom};
    exp_i   = {$urandom, $urandom};
    mod_i   = {$urandom, $urandom};
  endtask

  // Waits (bounded) for done_o; optionally pulses start_i at edge N+pulse_at.
  task automatic wait_done(input string nm, input int lat, input logic [63:0] key,
                           input int pulse_at);
    int k = 0;
    int busy_cnt = 0;
    bit seen = 1'b0;
    while (!seen && k < lat + 16) begin
      tick();
      k++;
      start_i = 1'b0;
      if (done_o) seen = 1'b1;
      else if (busy_o) busy_cnt++;
      if (k == pulse_at - 1) begin
        start_i = 1'b1;
        base_i  = 64'd2;
        exp_i   = 64'd10;
        mod_i   = 64'd1000;
      end
    end
    check({nm, " latency"}, 64'(k), 64'(lat));
    check({nm, " key"}, key_o, key);
    check({nm, " busy cycles"}, 64'(busy_cnt), 64'(lat - 1));
    check({nm, " busy at done"}, 64'(busy_o), 64'd0);
  endtask

  initial begin
    int cnt;

    vecs[0] = '{"3^5%7",        64'd3,  64'd5,   64'd7,    64'd5,    4289};
    vecs[1] = '{"max^2%big",    '1,     64'd2,   MBig,     64'd3364, 4225};
    vecs[2] = '{"2^0%1000",     64'd2,  64'd0,   64'd1000, 64'd1,    4161};
    vecs[3] = '{"2^10%1000",    64'd2,  64'd10,  64'd1000, 64'd24,   4289};
    vecs[4] = '{"mod1",         64'd7,  64'd9,   64'd1,    64'd0,    1};
    vecs[5] = '{"2^64%big",     64'd2,  64'd64,  MBig,     64'd59,   4225};
    vecs[6] = '{"mod0",         64'd9,  64'd9,   64'd0,    64'd0,    1};
    vecs[7] = '{"10^2%7",       64'd10, 64'd2,   64'd7,    64'd2,    4225};
    vecs[8] = '{"5^3%13",       64'd5,  64'd3,   64'd13,   64'd8,    4289};
    vecs[9] = '{"3^allones%2",  64'd3,  '1,      64'd2,    64'd1,    8257};

    #1;
    check("reset key", key_o, 64'd0);
    check("reset done", 64'(done_o), 64'd0);
    check("reset busy", 64'(busy_o), 64'd0);
    repeat (3) tick();
    rst = 1'b1;
    tick();

    for (int i = 0; i < 10; i++) begin
      do_start(vecs[i].b, vecs[i].e, vecs[i].m);
      wait_done(vecs[i].nm, vecs[i].lat, vecs[i].key, 0);
    end

    // Start during a run is ignored; done then holds while idle.
    do_start(64'd3, 64'd5, 64'd7);
    wait_done("ignored start", 4289, 64'd5, 100);
    cnt = 0;
    repeat (20) begin
      tick();
      if (done_o && key_o == 64'd5 && !busy_o) cnt++;
    end
    check("done hold 20", 64'(cnt), 64'd20);

    // Restart from DONE: done drops after one edge, key holds its old value.
    do_start(64'd2, 64'd0, 64'd1000);
    tick();
    check("restart done low", 64'(done_o), 64'd0);
    check("restart key held", key_o, 64'd5);
    check("restart busy", 64'(busy_o), 64'd1);
    wait_done("restart", 4160, 64'd1, 0);

    // Asynchronous reset mid-run, then silence without a new start.
    do_start(64'd3, 64'd5, 64'd7);
    repeat (2000) tick();
    rst = 1'b0;
    #1;
    check("midrun rst key", key_o, 64'd0);
    check("midrun rst done", 64'(done_o), 64'd0);
    check("midrun rst busy", 64'(busy_o), 64'd0);
    repeat (3) tick();
    rst = 1'b1;
    cnt = 0;
    repeat (5000) begin
      tick();
      if (key_o != 64'd0 || done_o || busy_o) cnt++;
    end
    check("post rst quiet", 64'(cnt), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
